// File: rtl/bridge_pkg.sv
// Shared types and constants for the Harvard-to-single-bus bridge.
// TIMEOUT_LIMIT_DEFAULT applies only when BRIDGE_TIMEOUT_EN is defined.
package bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecide,
        StData,
        StCommit
    } state_e;

    localparam logic [3:0]  BYTEENABLE_ALL        = 4'b1111;
    localparam int unsigned TIMEOUT_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/harvard_bus_bridge_if.sv
// Avalon-style memory bus between the bridge (master) and the memory system (slave).
interface harvard_bus_bridge_if;

    logic [31:0] address;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, writedata, read, write, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, writedata, read, write, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/harvard_bus_bridge.sv
// Serialises CPU instruction fetch and data access onto one bus, then strobes clk_enable.
// Optional wait-cycle timeout with sticky bus_error is built when BRIDGE_TIMEOUT_EN is defined.
module harvard_bus_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instr_address,
    output logic [31:0]                 instr_readdata,
    input  logic [31:0]                 data_address,
    input  logic [31:0]                 data_writedata,
    input  logic                        data_read,
    input  logic                        data_write,
    output logic [31:0]                 data_readdata,
    output logic                        clk_enable,
    output logic                        bus_error,
    harvard_bus_bridge_if.master        bus
);

    if (TIMEOUT_LIMIT < 1 || TIMEOUT_LIMIT > 65535) begin : g_limit_check
        $error("TIMEOUT_LIMIT out of range 1..65535");
    end

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic        timeout_hit;
    logic        xfer_done;
    logic        data_is_read;

    assign data_is_read = data_read & ~data_write;

`ifdef BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        berr_q, berr_d;
    logic        in_xfer;

    always_comb begin
        in_xfer     = (state_q == StFetch) || (state_q == StData);
        // Abort on the cycle that would be the TIMEOUT_LIMIT-th wait cycle.
        timeout_hit = in_xfer && bus.waitrequest &&
                      (({16'd0, wait_cnt_q} + 32'd1) >= TIMEOUT_LIMIT);
        wait_cnt_d  = (in_xfer && bus.waitrequest && !timeout_hit) ? wait_cnt_q + 16'd1 : 16'd0;
        berr_d      = berr_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 16'd0;
            berr_q     <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            berr_q     <= berr_d;
        end
    end

    assign bus_error = berr_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    assign xfer_done = ~bus.waitrequest | timeout_hit;

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        data_d         = data_q;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 32'd0;
        bus.writedata  = 32'd0;
        bus.byteenable = BYTEENABLE_ALL;
        clk_enable     = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.read    = 1'b1;
                bus.address = instr_address;
                if (xfer_done) begin
                    instr_d = timeout_hit ? 32'd0 : bus.readdata;
                    state_d = StDecide;
                end
            end
            StDecide: state_d = (data_read | data_write) ? StData : StCommit;
            StData: begin
                bus.address   = data_address;
                bus.writedata = data_writedata;
                bus.write     = data_write;
                bus.read      = data_is_read;
                if (xfer_done) begin
                    if (data_is_read) begin
                        data_d = timeout_hit ? 32'd0 : bus.readdata;
                    end
                    state_d = StCommit;
                end
            end
            StCommit: begin
                clk_enable = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            instr_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
    end

    assign instr_readdata = instr_q;
    assign data_readdata  = data_q;

endmodule

// File: tb/tb_harvard_bus_bridge.sv
// Bench for harvard_bus_bridge: instruction-level model expanded into per-cycle expectations.
// Covers both builds; the timeout path is exercised when BRIDGE_TIMEOUT_EN is defined.
module tb_harvard_bus_bridge;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned TLIM  = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TLIM  = 255;
    localparam bit          TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_address = 32'd0;
    logic [31:0] data_address = 32'd0;
    logic [31:0] data_writedata = 32'd0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] instr_readdata;
    logic [31:0] data_readdata;
    logic        clk_enable;
    logic        bus_error;

    harvard_bus_bridge_if bus ();

    harvard_bus_bridge #(
        .TIMEOUT_LIMIT(TLIM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .data_address  (data_address),
        .data_writedata(data_writedata),
        .data_read     (data_read),
        .data_write    (data_write),
        .data_readdata (data_readdata),
        .clk_enable    (clk_enable),
        .bus_error     (bus_error),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // One bus cycle: stimulus for that cycle plus every output it must show.
    typedef struct {
        logic        rst;
        logic [31:0] ia, da, wd;
        logic        dr, dw, wt;
        logic [31:0] rdata;
        logic        e_rd, e_wr, e_ce, e_berr;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    } cyc_t;

    cyc_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    logic [31:0] s_ia = 0, s_da = 0, s_wd = 0;
    logic        s_dr = 0, s_dw = 0;
    logic [31:0] m_ird = 0, m_drd = 0;
    logic        m_berr = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic push(input logic rst, input logic wt, input logic [31:0] rdata,
                        input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ce);
        cyc_t c;
        c.rst = rst;  c.ia = s_ia;  c.da = s_da;  c.wd = s_wd;
        c.dr = s_dr;  c.dw = s_dw;  c.wt = wt;    c.rdata = rdata;
        c.e_rd = rd;  c.e_wr = wr;  c.e_addr = addr;  c.e_wdata = wdata;
        c.e_ce = ce;  c.e_ird = m_ird;  c.e_drd = m_drd;  c.e_berr = m_berr;
        q.push_back(c);
    endtask

    // op: 0 none, 1 load, 2 store, 3 load+store (store wins).
    task automatic gen_instr(input logic [31:0] ia, input logic [31:0] iw, input int op,
                             input logic [31:0] da, input logic [31:0] wd,
                             input logic [31:0] rdat, input int fw, input int dw);
        logic rd_, wr_;
        s_ia = ia;  s_da = da;  s_wd = wd;
        s_dr = (op == 1 || op == 3);
        s_dw = (op >= 2);
        rd_  = (op == 1);
        wr_  = (op >= 2);
        for (int i = 0; i <= fw; i++) begin
            if (i < fw) begin
                push(1'b1, 1'b1, ~iw, 1'b1, 1'b0, ia, 32'd0, 1'b0);
                if (TO_EN && i == int'(TLIM) - 1) begin
                    m_ird  = 32'd0;
                    m_berr = 1'b1;
                    break;
                end
            end else begin
                push(1'b1, 1'b0, iw, 1'b1, 1'b0, ia, 32'd0, 1'b0);
                m_ird = iw;
            end
        end
        push(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        if (op != 0) begin
            for (int i = 0; i <= dw; i++) begin
                if (i < dw) begin
                    push(1'b1, 1'b1, ~rdat, rd_, wr_, da, wd, 1'b0);
                    if (TO_EN && i == int'(TLIM) - 1) begin
                        if (rd_) m_drd = 32'd0;
                        m_berr = 1'b1;
                        break;
                    end
                end else begin
                    push(1'b1, 1'b0, rdat, rd_, wr_, da, wd, 1'b0);
                    if (rd_) m_drd = rdat;
                end
            end
        end
        push(1'b1, 1'b0, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    // Fetch stalls for nwait cycles, then reset drops during the next wait cycle.
    task automatic gen_reset_mid_fetch(input logic [31:0] ia, input int nwait);
        s_ia = ia;  s_dr = 1'b0;  s_dw = 1'b0;
        for (int i = 0; i < nwait; i++) push(1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, ia, 32'd0, 1'b0);
        m_ird = 32'd0;  m_drd = 32'd0;  m_berr = 1'b0;
        push(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        push(1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            reset           = c.rst;
            instr_address   = c.ia;
            data_address    = c.da;
            data_writedata  = c.wd;
            data_read       = c.dr;
            data_write      = c.dw;
            bus.waitrequest = c.wt;
            bus.readdata    = c.rdata;
            @(negedge clk);
            chk($sformatf("read@%0d", cyc_no), {31'd0, bus.read}, {31'd0, c.e_rd});
            chk($sformatf("write@%0d", cyc_no), {31'd0, bus.write}, {31'd0, c.e_wr});
            chk($sformatf("address@%0d", cyc_no), bus.address, c.e_addr);
            chk($sformatf("writedata@%0d", cyc_no), bus.writedata, c.e_wdata);
            chk($sformatf("byteenable@%0d", cyc_no), {28'd0, bus.byteenable}, 32'hF);
            chk($sformatf("clk_enable@%0d", cyc_no), {31'd0, clk_enable}, {31'd0, c.e_ce});
            chk($sformatf("instr_readdata@%0d", cyc_no), instr_readdata, c.e_ird);
            chk($sformatf("data_readdata@%0d", cyc_no), data_readdata, c.e_drd);
            chk($sformatf("bus_error@%0d", cyc_no), {31'd0, bus_error}, {31'd0, c.e_berr});
            cyc_no++;
        end
    endtask

    initial begin
        int n;
        bus.waitrequest = 1'b0;
        bus.readdata    = 32'd0;
        #1 reset = 1'b0;

        push(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        push(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        push(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_q();

        // Non-memory instruction, zero wait.
        n = q.size();
        gen_instr(32'hBFC0_0000, 32'h2402_0005, 0, 32'd0, 32'd0, 32'd0, 0, 0);
        chk("len_nomem", 32'(q.size() - n), 32'd3);
        run_q();
        chk("t1_instr_readdata", instr_readdata, 32'h2402_0005);

        // Load with two data wait cycles.
        n = q.size();
        gen_instr(32'hBFC0_0004, 32'h8C02_0000, 1, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2);
        chk("len_load_2wait", 32'(q.size() - n), 32'd6);
        run_q();
        chk("t2_data_readdata", data_readdata, 32'hDEAD_BEEF);

        // Store with one fetch wait cycle.
        n = q.size();
        gen_instr(32'hBFC0_0008, 32'hAC03_0004, 2, 32'h0000_2004, 32'h1234_5678, 32'h0, 1, 0);
        chk("len_store_fwait", 32'(q.size() - n), 32'd5);
        run_q();

        // Read and write together: write only, load result unchanged.
        gen_instr(32'hBFC0_000C, 32'hAC04_0000, 3, 32'h0000_3000, 32'hCAFE_F00D,
                  32'h5555_5555, 0, 1);
        run_q();
        chk("t4_data_readdata_kept", data_readdata, 32'hDEAD_BEEF);

        // Load with fetch waits.
        gen_instr(32'hBFC0_0010, 32'h8C05_0008, 1, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 2, 0);
        run_q();
        chk("t5_data_readdata", data_readdata, 32'h0BAD_F00D);

        // Long fetch stall: completes late, or aborts with bus_error in the timeout build.
        n = q.size();
        gen_instr(32'hBFC0_0014, 32'h2406_0001, 0, 32'h0, 32'h0, 32'h0, 10, 0);
        chk("len_long_fetch", 32'(q.size() - n), TO_EN ? 32'd6 : 32'd13);
        run_q();
        chk("t6_bus_error", {31'd0, bus_error}, TO_EN ? 32'd1 : 32'd0);
        chk("t6_instr_readdata", instr_readdata, TO_EN ? 32'd0 : 32'h2406_0001);

        // Reset mid-fetch, then restart from the new fetch address.
        gen_reset_mid_fetch(32'hBFC0_0018, TO_EN ? 2 : 4);
        gen_instr(32'hBFC0_0100, 32'h2407_0007, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        run_q();
        chk("t7_instr_readdata", instr_readdata, 32'h2407_0007);
        chk("t7_bus_error", {31'd0, bus_error}, 32'd0);
        chk("t7_data_readdata", data_readdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/harvard_bus_bridge.md
HARVARD_BUS_BRIDGE -- requirements
Module: harvard_bus_bridge

Interface
REQ-001 Parameter: TIMEOUT_LIMIT, 255, max waitrequest cycles per bus transaction (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 instr_address  input  32  CPU fetch byte address.
REQ-005 instr_readdata  output  32  fetched word held to CPU.
REQ-006 data_address / data_writedata  input  32 each  CPU data byte address / store word.
REQ-007 data_read / data_write  input  1 each  CPU data access request.
REQ-008 data_readdata  output  32  loaded word held to CPU.
REQ-009 clk_enable  output  1  one-cycle CPU advance strobe.
REQ-010 address / writedata  output  32 each  bus address / store word.
REQ-011 read / write  output  1 each  bus strobes.
REQ-012 byteenable  output  4  always 4'b1111.
REQ-013 waitrequest  input  1  bus stall; transaction completes on a cycle with strobe high and waitrequest low.
REQ-014 readdata  input  32  bus read data, valid on completion cycle.
REQ-015 bus_error  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DECIDE, DATA, COMMIT.
REQ-017 IDLE: leave for FETCH on the first clock after reset deasserts.
REQ-018 FETCH: read=1, address=instr_address; on completion capture readdata into instr_readdata, go DECIDE.
REQ-019 DECIDE: one settle cycle, no bus strobe; go DATA if data_read|data_write, else COMMIT.
REQ-020 DATA: address=data_address; write=data_write, writedata=data_writedata; read=data_read&!data_write; on completion capture readdata into data_readdata (reads only), go COMMIT.
REQ-021 data_read and data_write both high SHALL perform the write only; data_readdata unchanged.
REQ-022 COMMIT: clk_enable=1 for exactly this cycle, go FETCH.
REQ-023 Bus outputs SHALL hold stable while waitrequest=1; read and write never both high.
REQ-024 Zero-wait latency: 3 cycles per non-memory instruction, 4 per load/store; each waitrequest cycle adds one.
REQ-025 instr_readdata and data_readdata SHALL change only on their capture cycles.
REQ-026 Outside COMMIT clk_enable SHALL be 0.

Reset
REQ-027 On reset=0 (any state, mid-transaction included), immediately: state=IDLE, read=write=clk_enable=0, address=writedata=0, instr_readdata=data_readdata=0, bus_error=0.
REQ-028 An in-flight transaction aborted by reset SHALL NOT be retried after release.

Configuration
REQ-029 Macro BRIDGE_TIMEOUT_EN defined: wait counter resets each transaction start; when it reaches TIMEOUT_LIMIT the transaction aborts, captured word is 32'h0000_0000, bus_error sets, FSM proceeds as if complete.
REQ-030 BRIDGE_TIMEOUT_EN undefined: no counter, bus_error tied 0, waits indefinitely.

Structure
REQ-031 Shared package bridge_pkg SHALL hold the state enum typedef, BYTEENABLE_ALL=4'b1111, and the default TIMEOUT_LIMIT.
REQ-032 Single module; no sub-module (timeout counter is inline, under the macro).

Verification
REQ-033 No waitrequest, instr at 0xBFC00000 = 0x24020005, no data access -> read high 1 cycle at 0xBFC00000, clk_enable pulses 3 cycles after FETCH entry, instr_readdata=0x24020005.
REQ-034 Load: data_read=1, data_address=0x1000, bus returns 0xDEADBEEF after 2 waitrequest cycles -> address 0x1000 stable 3 cycles, data_readdata=0xDEADBEEF, clk_enable 6 cycles after FETCH entry.
REQ-035 Store: data_write=1, data_address=0x2004, data_writedata=0x12345678 -> write=1, writedata=0x12345678, byteenable=4'b1111, read=0 throughout.
REQ-036 data_read=data_write=1 -> only write strobe issued; data_readdata keeps prior value.
REQ-037 reset=0 during 5th waitrequest cycle of a fetch -> all outputs 0 same cycle; after release FETCH restarts at current instr_address.
REQ-038 BRIDGE_TIMEOUT_EN, TIMEOUT_LIMIT=4, waitrequest held 1 -> abort after 4 wait cycles, bus_error=1 until reset, instr_readdata=0, clk_enable still pulses.
